// File: rtl/cpu_pkg.sv
// Shared types for the forwarding/hazard control slice: mux selects,
// pipeline tracking entries and the operand-select helper functions.
package cpu_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_ALU = 2'b01,
        FWD_DW  = 2'b10
    } fwd_sel_t;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       fs;
    } trk_t;

    // Youngest producer wins; XZR reads always come from the register file.
    function automatic fwd_sel_t fwd_select(input logic use_src, input logic [4:0] src,
                                            input trk_t ex, input trk_t mem);
        fwd_sel_t sel;
        sel = FWD_REG;
        if (use_src && src != XZR) begin
            if (ex.valid && ex.wr && ex.rd == src)
                sel = FWD_ALU;
            else if (mem.valid && mem.wr && mem.rd == src)
                sel = FWD_DW;
        end
        return sel;
    endfunction

    function automatic logic load_hit(input logic use_src, input logic [4:0] src,
                                      input trk_t ex);
        return use_src && src != XZR && ex.valid && ex.ld && ex.rd == src;
    endfunction

endpackage

// File: rtl/forward_hazard_unit_if.sv
// Decode-stage request and forwarding/stall response bundle.
interface forward_hazard_unit_if
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rn;
    logic [4:0]       id_rm;
    logic             id_use_rn;
    logic             id_use_rm;
    logic [4:0]       id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_flag_set;
    logic             id_flag_read;
    logic             flush;
    logic             stall;
    fwd_sel_t         forward_ctrl_one;
    fwd_sel_t         forward_ctrl_two;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
               id_reg_write, id_mem_read, id_flag_set, id_flag_read, flush,
        input  stall, forward_ctrl_one, forward_ctrl_two, stall_count
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
               id_reg_write, id_mem_read, id_flag_set, id_flag_read, flush,
        output stall, forward_ctrl_one, forward_ctrl_two, stall_count
    );
endinterface

// File: rtl/hazard_stage_reg.sv
// One pipeline tracking stage; a bubble loads an all-zero (invalid) entry.
module hazard_stage_reg
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bubble,
    input  trk_t d,
    output trk_t q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (bubble)
            q <= '0;
        else
            q <= d;
    end
endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding-select and load-use/flag-use stall control for the decode stage,
// with a saturating stall counter for performance debug.
module forward_hazard_unit
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic                  clk,
    input  logic                  reset,
    forward_hazard_unit_if.slave  bus
);
    trk_t             id_trk;
    trk_t             ex_trk;
    trk_t             mem_trk;
    logic             load_use;
    logic             flag_haz;
    logic             stall;
    logic             ex_bubble;
    logic [CNT_W-1:0] stall_cnt_reg;

    always_comb begin
        id_trk       = '0;
        id_trk.valid = 1'b1;
        id_trk.rd    = bus.id_rd;
        id_trk.wr    = bus.id_reg_write && (bus.id_rd != XZR);
        id_trk.ld    = bus.id_mem_read;
        id_trk.fs    = bus.id_flag_set;
    end

    always_comb begin
        load_use  = load_hit(bus.id_use_rn, bus.id_rn, ex_trk) ||
                    load_hit(bus.id_use_rm, bus.id_rm, ex_trk);
        flag_haz  = bus.id_flag_read && ex_trk.valid && ex_trk.fs;
        // Flush wins over stall: the killed instruction becomes a bubble instead.
        stall     = bus.id_valid && !bus.flush && (load_use || flag_haz);
        ex_bubble = !bus.id_valid || bus.flush || stall;
    end

    hazard_stage_reg u_ex_stage (
        .clk    (clk),
        .reset  (reset),
        .bubble (ex_bubble),
        .d      (id_trk),
        .q      (ex_trk)
    );

    // MEM always takes the old EX entry, even while EX receives a bubble.
    hazard_stage_reg u_mem_stage (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .d      (ex_trk),
        .q      (mem_trk)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt_reg <= '0;
        else if (stall && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end

    always_comb begin
        bus.stall            = stall;
        bus.stall_count      = stall_cnt_reg;
        bus.forward_ctrl_one = fwd_select(bus.id_use_rn, bus.id_rn, ex_trk, mem_trk);
        bus.forward_ctrl_two = fwd_select(bus.id_use_rm, bus.id_rm, ex_trk, mem_trk);
        if (stall) begin
            bus.forward_ctrl_one = FWD_REG;
            bus.forward_ctrl_two = FWD_REG;
        end
    end
endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed instruction-stream vectors for forward_hazard_unit plus saturation
// and asynchronous-reset sequences.
module tb_forward_hazard_unit;
    localparam int CNT_W = 4;

    typedef struct {
        string      name;
        logic       vld;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       use_rn;
        logic       use_rm;
        logic [4:0] rd;
        logic       wr;
        logic       mr;
        logic       fs;
        logic       fr;
        logic       fl;
        logic       exp_stall;
        logic [1:0] exp_f1;
        logic [1:0] exp_f2;
        int         exp_cnt;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs[$];

    forward_hazard_unit_if #(.CNT_W(CNT_W)) bus ();

    forward_hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic vld, logic [4:0] rn, logic [4:0] rm,
                                logic use_rn, logic use_rm, logic [4:0] rd, logic wr,
                                logic mr, logic fs, logic fr, logic fl, logic es,
                                logic [1:0] f1, logic [1:0] f2, int cnt);
        vec_t v;
        v.name = name; v.vld = vld; v.rn = rn; v.rm = rm; v.use_rn = use_rn;
        v.use_rm = use_rm; v.rd = rd; v.wr = wr; v.mr = mr; v.fs = fs; v.fr = fr;
        v.fl = fl; v.exp_stall = es; v.exp_f1 = f1; v.exp_f2 = f2; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.id_valid     = v.vld;
        bus.id_rn        = v.rn;
        bus.id_rm        = v.rm;
        bus.id_use_rn    = v.use_rn;
        bus.id_use_rm    = v.use_rm;
        bus.id_rd        = v.rd;
        bus.id_reg_write = v.wr;
        bus.id_mem_read  = v.mr;
        bus.id_flag_set  = v.fs;
        bus.id_flag_read = v.fr;
        bus.flush        = v.fl;
    endtask

    task automatic check(input string name, input logic es, input logic [1:0] f1,
                         input logic [1:0] f2, input int cnt);
        checks++;
        if (bus.stall !== es || bus.forward_ctrl_one !== f1 || bus.forward_ctrl_two !== f2 ||
            int'(bus.stall_count) != cnt) begin
            errors++;
            $display("FAIL %s: got stall=%0b f1=%b f2=%b cnt=%0d, want stall=%0b f1=%b f2=%b cnt=%0d",
                     name, bus.stall, bus.forward_ctrl_one, bus.forward_ctrl_two,
                     bus.stall_count, es, f1, f2, cnt);
        end else begin
            $display("ok   %s: stall=%0b f1=%b f2=%b cnt=%0d", name, bus.stall,
                     bus.forward_ctrl_one, bus.forward_ctrl_two, bus.stall_count);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        vec_t ldv;
        vec_t usev;
        int   stalls_seen;
        checks = 0;
        errors = 0;
        idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

        //         name              vld rn  rm  urn urm rd  wr mr fs fr fl  st f1     f2     cnt
        vecs.push_back(mk("addi_x1",      1, 31, 0,  1,  0,  1,  1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("adds_x3_fwd",  1, 1,  2,  1,  1,  3,  1, 0, 1, 0, 0, 0, 2'b01, 2'b00, 0));
        vecs.push_back(mk("addi_x1_b",    1, 31, 0,  1,  0,  1,  1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("nop",          0, 0,  0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("subs_dist2",   1, 1,  1,  1,  1,  4,  1, 0, 1, 0, 0, 0, 2'b10, 2'b10, 0));
        vecs.push_back(mk("bcond_stall",  1, 0,  0,  0,  0,  0,  0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0));
        vecs.push_back(mk("bcond_go",     1, 0,  0,  0,  0,  0,  0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk("adds_x3_b",    1, 2,  2,  1,  1,  3,  1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk("bcond_flush",  1, 0,  0,  0,  0,  0,  0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk("ldur_x5",      1, 1,  0,  1,  0,  5,  1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk("ld_use_stall", 1, 5,  0,  1,  0,  5,  1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1));
        vecs.push_back(mk("ld_use_dw",    1, 5,  0,  1,  0,  5,  1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2));
        vecs.push_back(mk("addi_xzr",     1, 31, 0,  1,  0,  31, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2));
        vecs.push_back(mk("add_from_xzr", 1, 31, 31, 1,  1,  2,  1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2));
        vecs.push_back(mk("ldur_x6",      1, 2,  0,  1,  0,  6,  1, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2));
        vecs.push_back(mk("ldur_x7_stall",1, 6,  0,  1,  0,  7,  1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2));
        vecs.push_back(mk("ldur_x7_dw",   1, 6,  0,  1,  0,  7,  1, 1, 0, 0, 0, 0, 2'b10, 2'b00, 3));
        vecs.push_back(mk("stur_rm_stall",1, 6,  7,  1,  1,  0,  0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3));
        vecs.push_back(mk("stur_rm_dw",   1, 6,  7,  1,  1,  0,  0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 4));
        vecs.push_back(mk("addi_x8_a",    1, 31, 0,  1,  0,  8,  1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4));
        vecs.push_back(mk("addi_x8_b",    1, 31, 0,  1,  0,  8,  1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4));
        vecs.push_back(mk("ex_priority",  1, 8,  8,  1,  1,  9,  1, 0, 0, 0, 0, 0, 2'b01, 2'b01, 4));
        vecs.push_back(mk("adds_x10",     1, 9,  0,  1,  0,  10, 1, 0, 1, 0, 0, 0, 2'b01, 2'b00, 4));
        vecs.push_back(mk("add_x11_gap",  1, 31, 31, 1,  1,  11, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4));
        vecs.push_back(mk("bcond_gap1",   1, 11, 0,  0,  0,  0,  0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4));

        apply(idle);
        reset = 1'b0;
        next_cycle();
        next_cycle();
        check("reset_state", 0, 2'b00, 2'b00, 0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            #3;
            check(vecs[i].name, vecs[i].exp_stall, vecs[i].exp_f1, vecs[i].exp_f2, vecs[i].exp_cnt);
            next_cycle();
        end

        // 18 load-use pairs: counter (at 4) must stop at all ones.
        ldv  = mk("sat_ld",  1, 31, 0, 1, 0, 13, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        usev = mk("sat_use", 1, 13, 0, 1, 0, 14, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        stalls_seen = 0;
        for (int i = 0; i < 18; i++) begin
            apply(ldv);
            next_cycle();
            apply(usev);
            #3;
            if (bus.stall === 1'b1) stalls_seen++;
            next_cycle();
            next_cycle();
        end
        checks++;
        if (stalls_seen != 18) begin
            errors++;
            $display("FAIL sat_stalls: got %0d stall cycles, want 18", stalls_seen);
        end else begin
            $display("ok   sat_stalls: %0d stall cycles", stalls_seen);
        end
        apply(idle);
        #3;
        check("sat_count", 0, 2'b00, 2'b00, 15);
        next_cycle();

        // Reset dropped in the middle of a load-use stall.
        apply(mk("rst_ld", 1, 31, 0, 1, 0, 14, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        next_cycle();
        apply(mk("rst_use", 1, 14, 0, 1, 0, 15, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        #2;
        check("pre_rst_stall", 1, 2'b00, 2'b00, 15);
        reset = 1'b0;
        #1;
        check("async_rst", 0, 2'b00, 2'b00, 0);
        next_cycle();
        reset = 1'b1;
        #3;
        check("post_rst_first", 0, 2'b00, 2'b00, 0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
